multicycle_core: RTL and testbench
==================================

Name: multicycle_core

Overview:
- Parametrised multi-cycle RV-I integer core; the next generation of the single-cycle top.
- Fetches through a valid/ready-style instruction port, decodes, executes and writes back over a FETCH/EXEC state machine.
- Adds control flow (JAL/JALR), LUI/AUIPC, EBREAK halt, an illegal-instruction trap and a commit trace port for the difftest bench.
- Sits between the simulation instruction memory and the bench monitor.

Parameters:
XLEN, 64, register/datapath width (32 or 64)
RESET_PC, 64'h8000_0000, PC value after reset (truncated to XLEN)
NREGS, 32, architectural register count (16 for RV-E or 32); register index width = log2(NREGS)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ifu_req_valid  out  1  fetch request; high throughout FETCH
ifu_req_addr  out  XLEN  fetch address, equals pc
ifu_rsp_valid  in  1  instruction returned this cycle
ifu_rsp_inst  in  32  instruction word, sampled when ifu_rsp_valid=1 in FETCH
pc  out  XLEN  current program counter
commit_valid  out  1  one-cycle pulse per retired instruction
commit_pc  out  XLEN  PC of the retired instruction
commit_inst  out  32  retired instruction word
commit_wen  out  1  retired instruction wrote a register (rd!=0)
commit_rd  out  log2(NREGS)  destination index
commit_wdata  out  XLEN  value written
halt  out  1  core stopped (sticky until reset)
halt_trap  out  1  1 = halted on illegal/misaligned, 0 = EBREAK
halt_code  out  XLEN  value of x10 at halt (0 = good trap)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. Registers change only on the rising edge of clk.
- Reset values:
  - state=FETCH, pc=RESET_PC.
  - commit_*=0, halt=0, halt_trap=0, halt_code=0.
  - All GPRs cleared to 0.
- rst asserted mid-instruction: EXEC abandoned with no register write and no commit; the fetch is dropped. Any ifu_rsp_valid during reset is ignored.
- States: FETCH, EXEC, HALT.
- FETCH:
  - ifu_req_valid=1, ifu_req_addr=pc.
  - On ifu_rsp_valid=1: latch ifu_rsp_inst into the internal IR, go to EXEC. A same-cycle response is allowed; the minimum CPI is 2.
  - ifu_rsp_valid outside FETCH is ignored.
- EXEC:
  - One cycle: decode IR, read rs1/rs2 combinationally, compute, write rd on the exiting edge.
  - commit_valid=1 with commit_* describing the instruction; return to FETCH with next pc.
  - commit_* are registered; they are valid in the first FETCH cycle after EXEC.
- Supported instructions: ADDI, ADD, SUB, LUI, AUIPC, JAL, JALR, EBREAK.
- Arithmetic:
  - Wraps modulo 2^XLEN; immediates are sign-extended to XLEN.
  - LUI: rd = sext(imm[31:12]<<12).
  - AUIPC: rd = pc + that value.
  - JAL/JALR: rd = pc+4.
  - JALR target = (rs1+imm) with bit0 cleared.
  - Other instructions: next pc = pc+4.
- x0 hardwired zero: writes with rd=0 are dropped (commit_wen=0), and reads return 0.
- Register-index limits:
  - With NREGS=16, any rs1/rs2/rd index ≥16 is illegal.
  - Same-register source and destination (e.g. ADD x5,x5,x5) uses the old value.
- EBREAK: no register write; commit_valid=1; halt=1, halt_trap=0, halt_code=x10; state→HALT.
- Illegal instruction, or a taken jump target with bit1=1:
  - No register write and no pc update.
  - commit_valid=0; halt=1, halt_trap=1, halt_code=x10; state→HALT.
- HALT: absorbing until rst. ifu_req_valid=0, commit_valid=0, pc frozen.

Test Plan:
- Reset then ADDI x1,x0,5 at 0x80000000 with the response in the same cycle → commit_valid 2 cycles after reset release, commit_rd=1, commit_wdata=5, pc=0x80000004.
- ADDI x1,x0,-1; ADD x2,x1,x1 with XLEN=64 → x2=0xFFFF_FFFF_FFFF_FFFE; repeat with XLEN=32 → x2=0xFFFF_FFFE.
- ifu_rsp_valid delayed by 3 cycles → ifu_req_valid and ifu_req_addr held stable for 4 cycles, IR captured once, no extra commit.
- JAL x1,+8 at 0x80000010 → x1=0x80000014, next pc=0x80000018. JALR x0,x1,3 with x1=0x80000020 → pc=0x80000022, so halt_trap=1 and pc stays at the JALR's address.
- ADDI x0,x0,7 → commit_wen=0, x0 reads 0. ADDI x10,x0,0 then EBREAK → halt=1, halt_trap=0, halt_code=0, ifu_req_valid=0 thereafter.
- rst asserted during EXEC of ADDI x3,x0,9 → x3 stays 0, no commit pulse, pc=RESET_PC next cycle. NREGS=16 with ADD x17,... → halt_trap=1.

Source files
------------

// File: rtl/multicycle_core_if.sv
// Instruction-fetch port between the core (master) and instruction memory (slave).
// The request holds steady until memory answers with a valid instruction word.
interface multicycle_core_if #(
  parameter int XLEN = 64
);
  logic            ifu_req_valid;
  logic [XLEN-1:0] ifu_req_addr;
  logic            ifu_rsp_valid;
  logic [31:0]     ifu_rsp_inst;

  modport master (
    output ifu_req_valid,
    output ifu_req_addr,
    input  ifu_rsp_valid,
    input  ifu_rsp_inst
  );

  modport slave (
    input  ifu_req_valid,
    input  ifu_req_addr,
    output ifu_rsp_valid,
    output ifu_rsp_inst
  );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle RV-I subset core: FETCH latches the instruction word, EXEC retires it
// in one cycle, HALT absorbs on EBREAK, illegal encodings or misaligned jump targets.
module multicycle_core #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          NREGS    = 32,
  localparam int         RIDX_W   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_core_if.master     ifu,
  output logic [XLEN-1:0]       pc,
  output logic                  commit_valid,
  output logic [XLEN-1:0]       commit_pc,
  output logic [31:0]           commit_inst,
  output logic                  commit_wen,
  output logic [RIDX_W-1:0]     commit_rd,
  output logic [XLEN-1:0]       commit_wdata,
  output logic                  halt,
  output logic                  halt_trap,
  output logic [XLEN-1:0]       halt_code
);

  localparam logic [XLEN-1:0] PC_RST   = RESET_PC[XLEN-1:0];
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] BIT0_CLR = ~XLEN'(1);
  localparam bit              SMALL_RF = (NREGS < 32);

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  function automatic logic signed [XLEN-1:0] sext12(input logic signed [11:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] sext21(input logic signed [20:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  state_t            state;
  logic              req_valid_q;
  logic [31:0]       ir;
  logic [XLEN-1:0]   gpr [NREGS];

  assign ifu.ifu_req_valid = req_valid_q;
  assign ifu.ifu_req_addr  = pc;

  // Decode stage: fields, immediates and register reads straight off the IR
  logic [6:0]              opcode;
  logic [4:0]              rd_f, rs1_f, rs2_f;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic [RIDX_W-1:0]       rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0]         rs1_val, rs2_val, x10_val;
  logic signed [XLEN-1:0]  imm_i, imm_u, imm_j;

  assign opcode  = ir[6:0];
  assign rd_f    = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1_f   = ir[19:15];
  assign rs2_f   = ir[24:20];
  assign funct7  = ir[31:25];
  assign rd_idx  = rd_f[RIDX_W-1:0];
  assign rs1_idx = rs1_f[RIDX_W-1:0];
  assign rs2_idx = rs2_f[RIDX_W-1:0];

  assign imm_i = sext12(ir[31:20]);
  assign imm_u = sext32({ir[31:12], 12'h000});
  assign imm_j = sext21({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});

  assign rs1_val = (rs1_idx == '0) ? '0 : gpr[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? '0 : gpr[rs2_idx];
  assign x10_val = gpr[RIDX_W'(10)];

  // Execute stage: result, next pc and trap qualification
  logic              legal, uses_rs1, uses_rs2, writes_rd, is_jump, is_ebreak;
  logic              bad_idx, illegal, wr_en;
  logic [XLEN-1:0]   result, target, next_pc;

  always_comb begin
    legal     = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_jump   = 1'b0;
    is_ebreak = 1'b0;
    result    = '0;
    target    = '0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          legal     = 1'b1;
          uses_rs1  = 1'b1;
          writes_rd = 1'b1;
          result    = rs1_val + imm_i;
        end
      end
      OP_REG: begin
        if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
          legal     = 1'b1;
          uses_rs1  = 1'b1;
          uses_rs2  = 1'b1;
          writes_rd = 1'b1;
          result    = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
        end
      end
      OP_LUI: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        result    = imm_u;
      end
      OP_AUI: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        result    = pc + imm_u;
      end
      OP_JAL: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        is_jump   = 1'b1;
        result    = pc + PC_STEP;
        target    = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          legal     = 1'b1;
          uses_rs1  = 1'b1;
          writes_rd = 1'b1;
          is_jump   = 1'b1;
          result    = pc + PC_STEP;
          target    = (rs1_val + imm_i) & BIT0_CLR;
        end
      end
      OP_SYS: begin
        if (ir == EBREAK_WORD) begin
          legal     = 1'b1;
          is_ebreak = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // An RV-E register file only decodes the low four index bits, so bit 4 set is a trap
  assign bad_idx = SMALL_RF && ((uses_rs1 && rs1_f[4]) || (uses_rs2 && rs2_f[4]) ||
                                (writes_rd && rd_f[4]));
  assign illegal = !legal || bad_idx || (is_jump && target[1]);
  assign wr_en   = writes_rd && (rd_idx != '0);
  assign next_pc = is_jump ? target : (pc + PC_STEP);

  // Writeback stage: register file, commit trace and control state on the EXEC exit edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      req_valid_q  <= 1'b1;
      pc           <= PC_RST;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_inst  <= '0;
      commit_wen   <= 1'b0;
      commit_rd    <= '0;
      commit_wdata <= '0;
      halt         <= 1'b0;
      halt_trap    <= 1'b0;
      halt_code    <= '0;
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else begin
      commit_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (ifu.ifu_rsp_valid) begin
            ir          <= ifu.ifu_rsp_inst;
            state       <= EXEC;
            req_valid_q <= 1'b0;
          end
        end
        EXEC: begin
          if (illegal) begin
            halt      <= 1'b1;
            halt_trap <= 1'b1;
            halt_code <= x10_val;
            state     <= HALT;
          end else begin
            commit_valid <= 1'b1;
            commit_pc    <= pc;
            commit_inst  <= ir;
            commit_wen   <= wr_en;
            commit_rd    <= wr_en ? rd_idx : '0;
            commit_wdata <= wr_en ? result : '0;
            if (wr_en) gpr[rd_idx] <= result;
            if (is_ebreak) begin
              halt      <= 1'b1;
              halt_trap <= 1'b0;
              halt_code <= x10_val;
              state     <= HALT;
            end else begin
              pc          <= next_pc;
              state       <= FETCH;
              req_valid_q <= 1'b1;
            end
          end
        end
        HALT: ;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench: three cores (RV64I, RV32I, RV64E) run one shared instruction
// stream in lockstep, each checked against hand-computed trace values.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        rsp_valid;
  logic [31:0] rsp_inst;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  multicycle_core_if #(.XLEN(64)) if_a ();
  multicycle_core_if #(.XLEN(32)) if_b ();
  multicycle_core_if #(.XLEN(64)) if_c ();

  assign if_a.ifu_rsp_valid = rsp_valid;
  assign if_a.ifu_rsp_inst  = rsp_inst;
  assign if_b.ifu_rsp_valid = rsp_valid;
  assign if_b.ifu_rsp_inst  = rsp_inst;
  assign if_c.ifu_rsp_valid = rsp_valid;
  assign if_c.ifu_rsp_inst  = rsp_inst;

  logic [63:0] pc_a, cpc_a, cwd_a, hc_a;
  logic [31:0] ci_a;
  logic [4:0]  crd_a;
  logic        cv_a, cw_a, h_a, ht_a;

  logic [31:0] pc_b, cpc_b, cwd_b, hc_b, ci_b;
  logic [4:0]  crd_b;
  logic        cv_b, cw_b, h_b, ht_b;

  logic [63:0] pc_c, cpc_c, cwd_c, hc_c;
  logic [31:0] ci_c;
  logic [3:0]  crd_c;
  logic        cv_c, cw_c, h_c, ht_c;

  multicycle_core #(.XLEN(64), .NREGS(32)) u_a (
    .clk(clk), .rst(rst), .ifu(if_a.master), .pc(pc_a),
    .commit_valid(cv_a), .commit_pc(cpc_a), .commit_inst(ci_a), .commit_wen(cw_a),
    .commit_rd(crd_a), .commit_wdata(cwd_a),
    .halt(h_a), .halt_trap(ht_a), .halt_code(hc_a)
  );

  multicycle_core #(.XLEN(32), .NREGS(32)) u_b (
    .clk(clk), .rst(rst), .ifu(if_b.master), .pc(pc_b),
    .commit_valid(cv_b), .commit_pc(cpc_b), .commit_inst(ci_b), .commit_wen(cw_b),
    .commit_rd(crd_b), .commit_wdata(cwd_b),
    .halt(h_b), .halt_trap(ht_b), .halt_code(hc_b)
  );

  multicycle_core #(.XLEN(64), .NREGS(16)) u_c (
    .clk(clk), .rst(rst), .ifu(if_c.master), .pc(pc_c),
    .commit_valid(cv_c), .commit_pc(cpc_c), .commit_inst(ci_c), .commit_wen(cw_c),
    .commit_rd(crd_c), .commit_wdata(cwd_c),
    .halt(h_c), .halt_trap(ht_c), .halt_code(hc_c)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst);
    rsp_valid = 1'b1;
    rsp_inst  = inst;
    step();
    rsp_valid = 1'b0;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    rsp_valid = 1'b1;
    rsp_inst  = 32'h0090_0193;
    repeat (3) step();
    chk("rst_pc",        pc_a, 64'h8000_0000);
    chk("rst_req_valid", {63'd0, if_a.ifu_req_valid}, 64'd1);
    chk("rst_req_addr",  if_a.ifu_req_addr, 64'h8000_0000);
    chk("rst_commit",    {63'd0, cv_a}, 64'd0);
    chk("rst_wdata",     cwd_a, 64'd0);
    chk("rst_halt",      {62'd0, h_a, ht_a}, 64'd0);
    chk("rst_hcode",     hc_a, 64'd0);
    chk("rst_pc32",      {32'd0, pc_b}, 64'h8000_0000);

    // ADDI x1,x0,5 answered in the first fetch cycle after reset release
    rst       = 1'b0;
    rsp_inst  = 32'h0050_0093;
    step();
    rsp_valid = 1'b0;
    chk("addi_exec_nocommit", {63'd0, cv_a}, 64'd0);
    step();
    chk("addi_cv",   {63'd0, cv_a}, 64'd1);
    chk("addi_rd",   {59'd0, crd_a}, 64'd1);
    chk("addi_wd",   cwd_a, 64'd5);
    chk("addi_cpc",  cpc_a, 64'h8000_0000);
    chk("addi_pc",   pc_a, 64'h8000_0004);
    chk("addi_inst", {32'd0, ci_a}, 64'h0050_0093);

    issue(32'hFFF0_0093);
    chk("addim1_wd",   cwd_a, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(32'h0010_8133);
    chk("add_x2_64",   cwd_a, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add_x2_32",   {32'd0, cwd_b}, 64'hFFFF_FFFE);
    issue(32'h4010_01B3);
    chk("sub_x3",      cwd_a, 64'd1);
    chk("sub_pc",      pc_a, 64'h8000_0010);

    issue(32'h0080_00EF);
    chk("jal_wd",      cwd_a, 64'h8000_0014);
    chk("jal_pc",      pc_a, 64'h8000_0018);
    chk("jal_wd32",    {32'd0, cwd_b}, 64'h8000_0014);

    // Memory answers three cycles late; the request must hold still meanwhile
    for (int i = 0; i < 3; i++) begin
      chk("wait_req_valid", {63'd0, if_a.ifu_req_valid}, 64'd1);
      chk("wait_req_addr",  if_a.ifu_req_addr, 64'h8000_0018);
      step();
    end
    chk("wait_req_valid3", {63'd0, if_a.ifu_req_valid}, 64'd1);
    chk("wait_req_addr3",  if_a.ifu_req_addr, 64'h8000_0018);
    chk("wait_nocommit",   {63'd0, cv_a}, 64'd0);
    issue(32'h1234_52B7);
    chk("lui_wd",      cwd_a, 64'h1234_5000);
    chk("lui_cpc",     cpc_a, 64'h8000_0018);
    step();
    chk("lui_single_commit", {63'd0, cv_a}, 64'd0);
    chk("lui_next_addr",     if_a.ifu_req_addr, 64'h8000_001C);

    issue(32'h8000_0337);
    chk("lui_neg_64",  cwd_a, 64'hFFFF_FFFF_8000_0000);
    chk("lui_neg_32",  {32'd0, cwd_b}, 64'h8000_0000);
    issue(32'h0000_1397);
    chk("auipc_wd",    cwd_a, 64'h8000_1020);

    issue(32'h0070_0013);
    chk("x0_cv",       {63'd0, cv_a}, 64'd1);
    chk("x0_wen",      {63'd0, cw_a}, 64'd0);
    issue(32'h0000_0433);
    chk("x0_read",     cwd_a, 64'd0);
    chk("x0_read_wen", {63'd0, cw_a}, 64'd1);
    issue(32'h0052_82B3);
    chk("add_same_reg", cwd_a, 64'h2468_A000);

    issue(32'h0000_0097);
    chk("auipc0_wd",   cwd_a, 64'h8000_0030);
    issue(32'hFF00_8093);
    chk("x1_setup",    cwd_a, 64'h8000_0020);
    issue(32'h0100_85E7);
    chk("jalr_wd",     cwd_a, 64'h8000_003C);
    chk("jalr_pc",     pc_a, 64'h8000_0030);
    issue(32'h0110_8667);
    chk("jalr_bit0_wd", cwd_a, 64'h8000_0034);
    chk("jalr_bit0_pc", pc_a, 64'h8000_0030);

    issue(32'h0550_0513);
    chk("x10_wd",      cwd_a, 64'h55);
    issue(32'h0000_08B3);
    chk("x17_rd64",    {59'd0, crd_a}, 64'd17);
    chk("x17_cv64",    {63'd0, cv_a}, 64'd1);
    chk("rve_halt",    {62'd0, h_c, ht_c}, 64'd3);
    chk("rve_nocommit", {63'd0, cv_c}, 64'd0);
    chk("rve_pc",      pc_c, 64'h8000_0034);
    chk("rve_hcode",   hc_c, 64'h55);

    // JALR x0,x1,3 lands on 0x80000022: misaligned, so trap without retiring
    issue(32'h0030_8067);
    chk("mis_halt",    {62'd0, h_a, ht_a}, 64'd3);
    chk("mis_nocommit", {63'd0, cv_a}, 64'd0);
    chk("mis_pc",      pc_a, 64'h8000_0038);
    chk("mis_hcode",   hc_a, 64'h55);
    chk("mis_req",     {63'd0, if_a.ifu_req_valid}, 64'd0);
    rsp_valid = 1'b1;
    repeat (3) step();
    rsp_valid = 1'b0;
    chk("halt_pc_frozen", pc_a, 64'h8000_0038);
    chk("halt_sticky",    {62'd0, h_a, ht_a, cv_a} , 64'd6);

    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("rst2_halt",   {62'd0, h_a, ht_a}, 64'd0);
    issue(32'h0000_0513);
    chk("x10_zero_rd", {59'd0, crd_a}, 64'd10);
    issue(32'h0010_0073);
    chk("ebreak_cv",   {63'd0, cv_a}, 64'd1);
    chk("ebreak_wen",  {63'd0, cw_a}, 64'd0);
    chk("ebreak_inst", {32'd0, ci_a}, 64'h0010_0073);
    chk("ebreak_halt", {62'd0, h_a, ht_a}, 64'd2);
    chk("ebreak_code", hc_a, 64'd0);
    chk("ebreak_req",  {63'd0, if_a.ifu_req_valid}, 64'd0);
    step();
    chk("ebreak_after", {62'd0, cv_a, if_a.ifu_req_valid}, 64'd0);

    // Reset lands while ADDI x3,x0,9 is in EXEC
    rst = 1'b1;
    step();
    rst       = 1'b0;
    rsp_valid = 1'b1;
    rsp_inst  = 32'h0090_0193;
    step();
    rsp_valid = 1'b0;
    rst       = 1'b1;
    step();
    chk("midrst_nocommit", {63'd0, cv_a}, 64'd0);
    chk("midrst_pc",       pc_a, 64'h8000_0000);
    chk("midrst_req",      {63'd0, if_a.ifu_req_valid}, 64'd1);
    rst = 1'b0;
    issue(32'h0001_86B3);
    chk("midrst_x3",       cwd_a, 64'd0);
    chk("midrst_cpc",      cpc_a, 64'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
